// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the MULT/MULTU/DIV/DIVU sequencer.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 5;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // Divide ops have op[1] set; signed ops have op[0] clear.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply or restoring divide.
// Divide mode leaves the new quotient bit clear; the caller inserts carry_o.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic               mode_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               carry_o
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_ext;
    logic [WIDTH:0] diff;

    // Multiply: conditional add into the upper half, then shift right.
    // Divide: shift left, trial-subtract, keep result when no borrow.
    always_comb begin
        addend  = acc_i[0] ? {1'b0, opnd_i} : '0;
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + addend;
        rem_ext = acc_i[2*WIDTH-1:WIDTH-1];
        // Remainder stays below the divisor, so a clear top bit means non-negative.
        diff    = rem_ext - {1'b0, opnd_i};
        carry_o = 1'b0;
        acc_o   = {sum, acc_i[WIDTH-1:1]};
        if (step_mode_e'(mode_i) == STEP_DIV) begin
            carry_o = ~diff[WIDTH];
            if (~diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] step_acc;
    logic               step_carry;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_i  (is_div_q),
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .acc_o   (step_acc),
        .carry_o (step_carry)
    );

    // Next-state logic: operand capture, iteration, sign fix-up and HI/LO write.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        a_neg = op_is_signed(op) & a[WIDTH-1];
        b_neg = op_is_signed(op) & b[WIDTH-1];
        a_abs = a_neg ? (~a + ONE_W) : a;
        b_abs = b_neg ? (~b + ONE_W) : b;
        prod  = neg_res_q ? (~acc_q + ONE_2W) : acc_q;
        quo   = neg_res_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
        rem   = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    is_div_d  = op_is_div(op);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = 1'b0;
                    // 2**CNT_W == WIDTH, so all ones is WIDTH-1.
                    cnt_d     = '1;
                    if (op_is_div(op) && (b == '0)) begin
                        dz_d    = 1'b1;
                        acc_d   = {{WIDTH{1'b0}}, a};
                        state_d = S_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        opnd_d  = op_is_div(op) ? b_abs : a_abs;
                        acc_d   = {{WIDTH{1'b0}}, (op_is_div(op) ? a_abs : b_abs)};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = {step_acc[2*WIDTH-1:1], (is_div_q ? step_carry : step_acc[0])};
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        hi_d  = acc_q[WIDTH-1:0];
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    // Output wiring.
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = done_q;
        hi          = hi_q;
        lo          = lo_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (dbz)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: MIPS semantics via wide integer arithmetic.
    function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] mhi, output logic [31:0] mlo, output logic mdz);
        longint      p, q, r;
        logic [63:0] pv;
        mdz = 1'b0;
        mhi = '0;
        mlo = '0;
        case (mop)
            OP_MULT: begin
                p   = longint'($signed(ma)) * longint'($signed(mb));
                pv  = p;
                mhi = pv[63:32];
                mlo = pv[31:0];
            end
            OP_MULTU: begin
                pv  = {32'b0, ma} * {32'b0, mb};
                mhi = pv[63:32];
                mlo = pv[31:0];
            end
            OP_DIV: begin
                if (mb == 0) begin
                    mhi = ma; mlo = '1; mdz = 1'b1;
                end else begin
                    q   = longint'($signed(ma)) / longint'($signed(mb));
                    r   = longint'($signed(ma)) % longint'($signed(mb));
                    mlo = q[31:0];
                    mhi = r[31:0];
                end
            end
            default: begin
                if (mb == 0) begin
                    mhi = ma; mlo = '1; mdz = 1'b1;
                end else begin
                    mlo = ma / mb;
                    mhi = ma % mb;
                end
            end
        endcase
    endfunction

    // Start an op (edge 1) and wait, bounded, for done; edges = edge on which done appeared.
    task automatic issue(input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib,
                         output int edges, output bit busy_ok);
        op = iop; a = ia; b = ib; start = 1'b1;
        tick;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        edges   = 1;
        busy_ok = busy;
        while (!done && edges < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick;
            edges++;
        end
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        tick; tick;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h expected 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h expected 0", lo); else n_pass++;
        n_checks++; if (dbz !== 1'b0) $display("FAIL reset_dbz: got %b expected 0", dbz); else n_pass++;
    endtask

    task automatic test_directed;
        logic [1:0]  d_op [6] = '{OP_MULTU, OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
        logic [31:0] d_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5};
        logic [31:0] d_b  [6] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
        logic [31:0] d_hi [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd5};
        logic [31:0] d_lo [6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFF};
        logic        d_dz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          d_lat[6] = '{34, 34, 34, 34, 34, 2};
        int          edges;
        bit          bok;
        for (int i = 0; i < 6; i++) begin
            issue(d_op[i], d_a[i], d_b[i], edges, bok);
            n_checks++; if (edges != d_lat[i]) $display("FAIL dir%0d_latency: got %0d expected %0d", i, edges, d_lat[i]); else n_pass++;
            n_checks++; if (!bok) $display("FAIL dir%0d_busy: got busy profile wrong expected high until done", i); else n_pass++;
            n_checks++; if (hi !== d_hi[i]) $display("FAIL dir%0d_hi: got %h expected %h", i, hi, d_hi[i]); else n_pass++;
            n_checks++; if (lo !== d_lo[i]) $display("FAIL dir%0d_lo: got %h expected %h", i, lo, d_lo[i]); else n_pass++;
            n_checks++; if (dbz !== d_dz[i]) $display("FAIL dir%0d_dbz: got %b expected %b", i, dbz, d_dz[i]); else n_pass++;
            tick;
            n_checks++; if (done !== 1'b0) $display("FAIL dir%0d_done_pulse: got %b expected 0", i, done); else n_pass++;
            n_checks++; if (hi !== d_hi[i] || lo !== d_lo[i]) $display("FAIL dir%0d_hold: got %h_%h expected %h_%h", i, hi, lo, d_hi[i], d_lo[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int edges;
        bit bok;
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, edges, bok);
        n_checks++; if (lo !== 32'hFFFFFFEB) $display("FAIL b2b_first_lo: got %h expected ffffffeb", lo); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL b2b_done_now: got %b expected 1", done); else n_pass++;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, edges, bok);
        n_checks++; if (edges != 34 || !bok) $display("FAIL b2b_accept: got latency %0d busy_ok %0d expected 34 1", edges, bok); else n_pass++;
        n_checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) $display("FAIL b2b_second: got %h_%h expected ffffffff_fffffffd", hi, lo); else n_pass++;
        tick;
    endtask

    task automatic test_div_zero_clear;
        int edges;
        bit bok;
        issue(OP_DIVU, 32'd5, 32'd0, edges, bok);
        n_checks++; if (dbz !== 1'b1 || edges != 2) $display("FAIL dz_set: got dbz %b latency %0d expected 1 2", dbz, edges); else n_pass++;
        tick;
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++; if (dbz !== 1'b0) $display("FAIL dz_clear_on_start: got %b expected 0", dbz); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL dz_restart_busy: got %b expected 1", busy); else n_pass++;
        edges = 1;
        while (!done && edges < 40) begin tick; edges++; end
        n_checks++; if (lo !== 32'd14 || hi !== 32'd2 || edges != 34) $display("FAIL dz_restart_result: got %h_%h lat %0d expected 2_14 34", hi, lo, edges); else n_pass++;
        tick;
    endtask

    task automatic test_flush;
        logic [31:0] ph, pl;
        bit          saw;
        int          edges;
        bit          bok;
        ph = hi; pl = lo;
        op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy); else n_pass++;
        saw = 1'b0;
        repeat (40) begin if (done) saw = 1'b1; tick; end
        n_checks++; if (saw) $display("FAIL flush_no_done: got done expected none"); else n_pass++;
        n_checks++; if (hi !== ph || lo !== pl) $display("FAIL flush_hold: got %h_%h expected %h_%h", hi, lo, ph, pl); else n_pass++;
        // flush on the FIX edge suppresses the write
        op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (32) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || lo !== pl) $display("FAIL flush_fix: got done %b busy %b lo %h expected 0 0 %h", done, busy, lo, pl); else n_pass++;
        // flush together with start in IDLE drops the start
        op = OP_MULTU; start = 1'b1; flush = 1'b1;
        tick;
        start = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_start_idle: got %b expected 0", busy); else n_pass++;
        issue(OP_MULTU, 32'd6, 32'd7, edges, bok);
        n_checks++; if (lo !== 32'd42 || hi !== 32'd0) $display("FAIL flush_restart: got %h_%h expected 0_2a", hi, lo); else n_pass++;
        tick;
    endtask

    task automatic test_start_ignored;
        int edges;
        op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
        tick;
        op = OP_DIV; a = 32'd1000; b = 32'd3;
        repeat (9) tick;
        start = 1'b0;
        edges = 10;
        while (!done && edges < 40) begin tick; edges++; end
        n_checks++; if (lo !== 32'd42 || hi !== 32'd0 || edges != 34) $display("FAIL start_ignored: got %h_%h lat %0d expected 0_2a 34", hi, lo, edges); else n_pass++;
        tick;
        n_checks++; if (busy !== 1'b0) $display("FAIL no_queue: got busy %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit saw;
        op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (18) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_ctrl: got busy %b done %b expected 0 0", busy, done); else n_pass++;
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0 || dbz !== 1'b0) $display("FAIL rst_mid_regs: got %h_%h dbz %b expected 0_0 0", hi, lo, dbz); else n_pass++;
        saw = 1'b0;
        repeat (40) begin if (done || busy) saw = 1'b1; tick; end
        n_checks++; if (saw) $display("FAIL rst_mid_quiet: got activity expected idle"); else n_pass++;
    endtask

    task automatic test_random;
        logic [1:0]  rop;
        logic [31:0] ra, rb, eh, el;
        logic        ed;
        int          edges, elat;
        bit          bok;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'h80000000;
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, eh, el, ed);
            elat = (rop[1] && rb == 0) ? 2 : 34;
            issue(rop, ra, rb, edges, bok);
            n_checks++; if (edges != elat || !bok) $display("FAIL rnd%0d_timing: got lat %0d busy_ok %0d expected %0d 1", i, edges, bok, elat); else n_pass++;
            n_checks++; if (hi !== eh || lo !== el || dbz !== ed) $display("FAIL rnd%0d_result op%0d a=%h b=%h: got %h_%h dbz %b expected %h_%h dbz %b", i, rop, ra, rb, hi, lo, dbz, eh, el, ed); else n_pass++;
            if ($urandom_range(0, 1) == 1) tick;
        end
        tick;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        test_reset;
        test_directed;
        test_back_to_back;
        test_div_zero_clear;
        test_flush;
        test_start_ignored;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
